led_blinker: RTL and testbench

//   Parametrised multi-channel LED driver; successor to the single-LED clock pass-through.

---
 rtl/led_blinker.sv | 100 ++++++++++
 tb/tb_led_blinker.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/led_blinker.sv
// Multi-channel LED driver: prescaled tick, shared blink phase and a chase
// position, with a per-channel OFF/ON/BLINK/CHASE mode select.
module led_blinker #(
  parameter int unsigned N_LEDS         = 4,
  parameter int unsigned PRESCALE       = 4,
  parameter int unsigned DIV_WIDTH      = 16,
  parameter int unsigned DEFAULT_PERIOD = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_enable,
  input  logic                  i_load,
  input  logic [DIV_WIDTH-1:0]  i_period,
  input  logic [2*N_LEDS-1:0]   i_mode,
  output logic [N_LEDS-1:0]     o_led,
  output logic                  o_tick
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_CHASE = 2'b11;

  logic [PRE_W-1:0]     pre_cnt;
  logic [DIV_WIDTH-1:0] hp_cnt;
  logic [DIV_WIDTH-1:0] period_q;
  logic [DIV_WIDTH-1:0] hp_lim_c;
  logic                 blink_q;
  logic [POS_W-1:0]     chase_pos;
  logic                 tick_c;
  logic                 hp_last_c;
  logic [N_LEDS-1:0]    led_next_c;

  // Internal tick on prescaler wrap; a zero period behaves as one tick
  assign tick_c    = i_enable && (pre_cnt == PRE_W'(PRESCALE - 1));
  assign hp_lim_c  = (period_q == '0) ? DIV_WIDTH'(1) : period_q;
  assign hp_last_c = (hp_cnt == hp_lim_c - DIV_WIDTH'(1));

  // Prescaler, half-period counter, blink phase and chase position
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pre_cnt   <= '0;
      hp_cnt    <= '0;
      blink_q   <= 1'b0;
      chase_pos <= '0;
      period_q  <= DIV_WIDTH'(DEFAULT_PERIOD);
      o_tick    <= 1'b0;
    end else if (i_load) begin
      period_q  <= i_period;
      pre_cnt   <= '0;
      hp_cnt    <= '0;
      blink_q   <= 1'b0;
      chase_pos <= '0;
      o_tick    <= 1'b0;
    end else begin
      o_tick <= tick_c;
      if (i_enable) begin
        if (tick_c) begin
          pre_cnt <= '0;
          if (hp_last_c) begin
            hp_cnt    <= '0;
            blink_q   <= ~blink_q;
            chase_pos <= (chase_pos == POS_W'(N_LEDS - 1)) ? '0 : chase_pos + POS_W'(1);
          end else begin
            hp_cnt <= hp_cnt + DIV_WIDTH'(1);
          end
        end else begin
          pre_cnt <= pre_cnt + PRE_W'(1);
        end
      end
    end
  end

  // Per-channel LED value from its mode and the current shared state
  always_comb begin
    led_next_c = '0;
    for (int k = 0; k < N_LEDS; k++) begin
      case (i_mode[2*k +: 2])
        MODE_OFF:   led_next_c[k] = 1'b0;
        MODE_ON:    led_next_c[k] = 1'b1;
        MODE_BLINK: led_next_c[k] = blink_q;
        MODE_CHASE: led_next_c[k] = (chase_pos == POS_W'(k));
        default:    led_next_c[k] = 1'b0;
      endcase
    end
  end

  // Registered LED outputs
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_led <= '0;
    end else begin
      o_led <= led_next_c;
    end
  end

endmodule

// File: tb/tb_led_blinker.sv
// Scoreboard bench for led_blinker: the driver pushes the expected outputs
// for each clock edge, a negedge monitor pops and compares them.
module tb_led_blinker;

  localparam int N   = 4;
  localparam int P   = 4;
  localparam int DW  = 16;
  localparam int DEF = 2;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          load;
  logic [DW-1:0] period;
  logic [2*N-1:0] mode;
  logic [N-1:0]  led;
  logic          tick;

  led_blinker #(
    .N_LEDS(N), .PRESCALE(P), .DIV_WIDTH(DW), .DEFAULT_PERIOD(DEF)
  ) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(enable), .i_load(load),
    .i_period(period), .i_mode(mode), .o_led(led), .o_tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [N-1:0] led;
    logic         tick;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_err  = 0;

  // Reference state: enabled edges since last restart and effective half-period
  int   m_n    = 0;
  int   m_per  = DEF;

  always @(posedge clk) cyc++;

  // Monitor: compare every expectation whose edge has already happened
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (led !== e.led || tick !== e.tick) begin
        n_err++;
        $display("FAIL scb cyc=%0d got led=%b tick=%b, want led=%b tick=%b",
                 e.cyc, led, tick, e.led, e.tick);
      end
    end
  end

  task automatic check_now(input string name, input logic [N-1:0] want_led, input logic want_tick);
    n_cmp++;
    if (led !== want_led || tick !== want_tick) begin
      n_err++;
      $display("FAIL %s got led=%b tick=%b, want led=%b tick=%b",
               name, led, tick, want_led, want_tick);
    end
  endtask

  // One clock edge of stimulus; expectation derived from tick count since restart
  task automatic step(input bit en, input bit ld, input int per_in, input logic [2*N-1:0] md);
    exp_t e;
    int   phase;
    enable = en;
    load   = ld;
    period = DW'(per_in);
    mode   = md;
    phase  = (m_n / P) / m_per;
    e.cyc  = cyc + 1;
    for (int k = 0; k < N; k++) begin
      case (md[2*k +: 2])
        2'b00:   e.led[k] = 1'b0;
        2'b01:   e.led[k] = 1'b1;
        2'b10:   e.led[k] = 1'(phase % 2);
        default: e.led[k] = ((phase % N) == k);
      endcase
    end
    if (ld) begin
      m_n   = 0;
      m_per = (per_in == 0) ? 1 : per_in;
    end else if (en) begin
      m_n++;
    end
    e.tick = !ld && en && (m_n % P == 0);
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    load   = 1'b0;
    period = '0;
    mode   = 8'h55;

    // Reset held with all channels ON: outputs stay dark
    repeat (5) begin
      @(negedge clk);
      check_now("reset_hold", 4'b0000, 1'b0);
    end
    rst_n = 1'b1;
    // First edge after release: all ON -> 1111
    step(1'b0, 1'b0, 0, 8'h55);
    step(1'b0, 1'b0, 0, 8'h55);

    // Blink, default half-period 2 ticks: toggle every 8 cycles
    repeat (40) step(1'b1, 1'b0, 0, 8'hAA);

    // Chase, all channels: one-hot walking position, 8 cycles per step
    repeat (40) step(1'b1, 1'b0, 0, 8'hFF);

    // Load period 0 mid-phase: treated as 1 tick, toggle every 4 cycles
    repeat (3) step(1'b1, 1'b0, 0, 8'hAA);
    step(1'b1, 1'b1, 0, 8'hAA);
    repeat (20) step(1'b1, 1'b0, 0, 8'hAA);

    // Load period 3: toggle every 12 cycles
    step(1'b1, 1'b1, 3, 8'hAA);
    repeat (30) step(1'b1, 1'b0, 0, 8'hAA);

    // Load on the cycle a tick would fire: load wins, no tick
    for (int i = 0; i < P && (m_n % P) != (P - 1); i++) step(1'b1, 1'b0, 0, 8'hAA);
    step(1'b1, 1'b1, 2, 8'hFF);
    repeat (20) step(1'b1, 1'b0, 0, 8'hFF);

    // Freeze mid-count then resume from the held count
    repeat (5) step(1'b1, 1'b0, 0, 8'hAA);
    repeat (20) step(1'b0, 1'b0, 0, 8'hAA);
    repeat (2) step(1'b0, 1'b0, 0, 8'h5A);
    repeat (20) step(1'b1, 1'b0, 0, 8'hAA);

    // Load while disabled still restarts timing
    step(1'b0, 1'b1, 1, 8'hFF);
    repeat (3) step(1'b0, 1'b0, 0, 8'hFF);
    repeat (16) step(1'b1, 1'b0, 0, 8'hFF);

    // Async reset between edges, mid-blink
    repeat (9) step(1'b1, 1'b0, 0, 8'hAA);
    #2 rst_n = 1'b0;
    #1 check_now("async_reset", 4'b0000, 1'b0);
    m_n   = 0;
    m_per = DEF;
    mode  = 8'hE4;
    repeat (2) begin
      @(negedge clk);
      check_now("reset_mid", 4'b0000, 1'b0);
    end
    rst_n = 1'b1;
    // Mixed modes {CHASE,BLINK,ON,OFF}: first value 0010
    repeat (40) step(1'b1, 1'b0, 0, 8'hE4);

    repeat (2) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain got %0d pending, want 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
